ts_packet_arbiter: RTL and testbench
====================================

// Module: ts_packet_arbiter
// PURPOSE
//  Round-robin reader for the four per-tuner reclock FIFOs. When a channel
//  signals a full 188-byte TS packet, the block streams exactly one packet
//  from that FIFO onto a single byte stream tagged with channel number, SOP and EOP.
//  Sits between the four reclock/prepare stages and the output formatter.
// PARAMETERS
//  NCH       4    number of input channels (fixed at 4 in this revision)
//  PKT_LEN   188  bytes per TS packet
//  GAP       3    idle cycles after each packet; covers the FIFO rdusedw update lag
// PORTS
//  SYS_CLK      in   1   system clock; every signal here is in this domain
//  RST          in   1   asynchronous reset, active-low
//  CH_FULL      in   4   per-channel GOT_FULL_PACKET (fifo used >= 188)
//  CH_ENABLE    in   4   per-channel enable; disabled channels are never granted
//  CH_DATA      in   32  per-channel FIFO q; ch n on [8n+7:8n]
//  CH_RD_REQ    out  4   per-channel FIFO rdreq
//  OUT_READY    in   1   downstream can take a whole packet (sampled only in IDLE)
//  OUT_DATA     out  8   packet byte
//  OUT_VALID    out  1   OUT_DATA valid
//  OUT_SOP      out  1   first byte of packet
//  OUT_EOP      out  1   last (188th) byte of packet
//  OUT_CH       out  2   source channel of the current byte
//  OUT_SYNC_ERR out  1   first byte != 8'h47 (optional feature only)
//  PKT_COUNT    out  64  per-channel packets forwarded, 16 bits each, ch n on [16n+15:16n], wraps
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer=3, so ch0 has first priority.
//  FIFO read latency is 1: q is valid on the cycle after rdreq.
//  eligible = CH_FULL & CH_ENABLE.
//  IDLE: if OUT_READY && |eligible: grant first eligible ch after rr pointer
//    (wrapping 0..3); latch grant into OUT_CH and rr pointer; go READ with rdcnt=0.
//  READ: CH_RD_REQ[grant]=1 for exactly PKT_LEN consecutive cycles (rdcnt 0..187).
//    No other CH_RD_REQ bit is ever high. At rdcnt=187 go DRAIN.
//  DRAIN: 1 cycle; the last byte is presented; then go WAIT with gapcnt=0.
//  WAIT: GAP cycles with no rdreq, then IDLE.
//  Output timing: OUT_VALID is high on the PKT_LEN cycles starting one cycle
//    after the first rdreq. OUT_DATA = registered CH_DATA[grant]. OUT_SOP is
//    high with byte 0; OUT_EOP is high with byte 187. OUT_CH is stable over the packet.
//  PKT_COUNT[grant] increments on the EOP cycle. 16-bit wrap: 16'hFFFF -> 0.
//  Packets are atomic: once READ starts, 188 bytes are always read and emitted,
//    even if CH_FULL, CH_ENABLE or OUT_READY drop mid-packet.
//  A CH_FULL asserted on a channel during another channel's packet is served
//    in a later IDLE cycle; nothing is lost, because the data stays in its FIFO.
//  If all four channels are eligible, grants are in order 0,1,2,3,0,...
//  Minimum packet-to-packet period = 1 (IDLE) + 188 + 1 + GAP cycles.
//  RST asserted mid-packet: immediate return to reset state; the partial packet
//    is abandoned with no EOP, and no counter increments.
// CONFIGURATION
//  TS_SYNC_CHECK_EN defined:
//    - Compare byte 0 of each packet with 8'h47.
//    - On mismatch, OUT_SYNC_ERR=1 on the SOP cycle only.
//    - SYNC_ERR_CNT (out, 16) increments, saturating at 16'hFFFF.
//    - The packet is still forwarded in full.
//  TS_SYNC_CHECK_EN undefined: OUT_SYNC_ERR tied 0; the SYNC_ERR_CNT port and
//    the compare logic are absent.
// TESTING
//  1 ch1 only full, OUT_READY=1, bytes 47,01..BB -> CH_RD_REQ=4'b0010 for 188 cyc;
//    OUT_VALID 188 cyc from the next cyc, SOP on 8'h47, EOP on 188th, OUT_CH=1; PKT_COUNT ch1=1.
//  2 all 4 full, held full -> grant order 0,1,2,3,0; each packet start exactly
//    190+GAP cycles after the previous one.
//  3 CH_FULL/CH_ENABLE dropped at byte 50 -> all 188 bytes still read and output, EOP present.
//  4 OUT_READY=0 with ch2 full -> no rdreq, stays IDLE; OUT_READY=1 -> read starts
//    next cycle.
//  5 RST low at byte 100 -> all outputs 0 next edge; after release ch0 is granted first.
//  6 (TS_SYNC_CHECK_EN) first byte 8'h48 -> OUT_SYNC_ERR=1 on SOP only, SYNC_ERR_CNT=1,
//    all 188 bytes still forwarded.

Source files
------------

// File: rtl/ts_packet_arbiter.sv
// Round-robin packet reader for four TS reclock FIFOs onto one tagged byte stream.
// Optional byte-0 sync check enabled by defining TS_SYNC_CHECK_EN.
module ts_packet_arbiter #(
  parameter int NCH     = 4,
  parameter int PKT_LEN = 188,
  parameter int GAP     = 3
) (
  input  logic               SYS_CLK,
  input  logic               RST,
  input  logic [NCH-1:0]     CH_FULL,
  input  logic [NCH-1:0]     CH_ENABLE,
  input  logic [8*NCH-1:0]   CH_DATA,
  output logic [NCH-1:0]     CH_RD_REQ,
  input  logic               OUT_READY,
  output logic [7:0]         OUT_DATA,
  output logic               OUT_VALID,
  output logic               OUT_SOP,
  output logic               OUT_EOP,
  output logic [1:0]         OUT_CH,
  output logic               OUT_SYNC_ERR,
`ifdef TS_SYNC_CHECK_EN
  output logic [15:0]        SYNC_ERR_CNT,
`endif
  output logic [16*NCH-1:0]  PKT_COUNT
);

  localparam int RW = $clog2(PKT_LEN);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WAIT
  } state_e;

  state_e          state_q;
  logic [1:0]      ptr_q;
  logic [1:0]      ch_q;
  logic [RW-1:0]   rdcnt_q;
  logic [GW-1:0]   gapcnt_q;
  logic [NCH-1:0]  rd_q;
  logic            valid_q;
  logic            sop_q;
  logic            eop_q;
  logic [15:0]     cnt_q [NCH];

  logic [NCH-1:0]  elig;
  logic            gnt_hit_d;
  logic [1:0]      gnt_ch_d;
  logic [1:0]      cand;
  logic [7:0]      byte_sel;
  logic            last_rd;
  logic            last_gap;

  assign elig     = CH_FULL & CH_ENABLE;
  assign last_rd  = (rdcnt_q == RW'(PKT_LEN - 1));
  assign last_gap = (gapcnt_q == GW'(GAP - 1));

  // Search starts one past the last grant and wraps back to it.
  always_comb begin
    gnt_hit_d = 1'b0;
    gnt_ch_d  = ptr_q;
    cand      = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = ptr_q + 2'(i);
      if (!gnt_hit_d && elig[cand]) begin
        gnt_hit_d = 1'b1;
        gnt_ch_d  = cand;
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      ptr_q    <= 2'd3;
      ch_q     <= '0;
      rdcnt_q  <= '0;
      gapcnt_q <= '0;
      rd_q     <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      for (int n = 0; n < NCH; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      valid_q <= (state_q == S_READ);
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (OUT_READY && gnt_hit_d) begin
            ch_q    <= gnt_ch_d;
            ptr_q   <= gnt_ch_d;
            rd_q    <= NCH'(1) << gnt_ch_d;
            rdcnt_q <= '0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          sop_q <= (rdcnt_q == '0);
          if (last_rd) begin
            eop_q       <= 1'b1;
            rd_q        <= '0;
            cnt_q[ch_q] <= cnt_q[ch_q] + 16'd1;
            state_q     <= S_DRAIN;
          end else begin
            rdcnt_q <= rdcnt_q + RW'(1);
          end
        end
        S_DRAIN: begin
          gapcnt_q <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (last_gap) begin
            state_q <= S_IDLE;
          end else begin
            gapcnt_q <= gapcnt_q + GW'(1);
          end
        end
      endcase
    end
  end

  // FIFO q arrives one cycle after rdreq, aligned with valid_q.
  assign byte_sel  = CH_DATA[8*ch_q +: 8];
  assign OUT_DATA  = valid_q ? byte_sel : 8'h00;
  assign OUT_VALID = valid_q;
  assign OUT_SOP   = sop_q;
  assign OUT_EOP   = eop_q;
  assign OUT_CH    = ch_q;
  assign CH_RD_REQ = rd_q;

  always_comb begin
    PKT_COUNT = '0;
    for (int n = 0; n < NCH; n++) begin
      PKT_COUNT[16*n +: 16] = cnt_q[n];
    end
  end

`ifdef TS_SYNC_CHECK_EN
  logic [15:0] serr_q;

  assign OUT_SYNC_ERR = sop_q && (byte_sel != 8'h47);
  assign SYNC_ERR_CNT = serr_q;

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      serr_q <= '0;
    end else if (OUT_SYNC_ERR && (serr_q != 16'hFFFF)) begin
      serr_q <= serr_q + 16'd1;
    end
  end
`else
  assign OUT_SYNC_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ts_packet_arbiter.sv
// Scoreboard bench for ts_packet_arbiter: FIFO models, packet-level
// reference arbiter and a negedge monitor.
module tb_ts_packet_arbiter;

  localparam int PL  = 188;
  localparam int GAP = 3;
  localparam int PER = 1 + PL + 1 + GAP;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  CH_FULL;
  logic [3:0]  CH_ENABLE;
  logic [31:0] CH_DATA;
  logic [3:0]  CH_RD_REQ;
  logic        OUT_READY;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_SOP;
  logic        OUT_EOP;
  logic [1:0]  OUT_CH;
  logic        OUT_SYNC_ERR;
  logic [63:0] PKT_COUNT;
`ifdef TS_SYNC_CHECK_EN
  logic [15:0] SYNC_ERR_CNT;
`endif

  ts_packet_arbiter dut (
    .SYS_CLK      (SYS_CLK),
    .RST          (RST),
    .CH_FULL      (CH_FULL),
    .CH_ENABLE    (CH_ENABLE),
    .CH_DATA      (CH_DATA),
    .CH_RD_REQ    (CH_RD_REQ),
    .OUT_READY    (OUT_READY),
    .OUT_DATA     (OUT_DATA),
    .OUT_VALID    (OUT_VALID),
    .OUT_SOP      (OUT_SOP),
    .OUT_EOP      (OUT_EOP),
    .OUT_CH       (OUT_CH),
    .OUT_SYNC_ERR (OUT_SYNC_ERR),
`ifdef TS_SYNC_CHECK_EN
    .SYNC_ERR_CNT (SYNC_ERR_CNT),
`endif
    .PKT_COUNT    (PKT_COUNT)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [1:0] ch;
  } beat_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  fifo [4][$];
  beat_t       exp_q [$];
  logic [3:0]  full_mask;
  logic [3:0]  rd_seen = '0;
  int          glog_ch [$];
  int          glog_cyc [$];

  int          cyc = 0;
  int          start = -1000;
  int          free_at = 0;
  logic [1:0]  ptr = 2'd3;
  logic [1:0]  gch = '0;
  int          mcnt [4] = '{default: 0};
  int          msync = 0;
  logic [3:0]  prev_rd = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, expv, cyc);
    end
  endtask

  function automatic logic [63:0] mcnt_packed();
    logic [63:0] v;
    v = '0;
    for (int n = 0; n < 4; n++) v[16*n +: 16] = 16'(mcnt[n]);
    return v;
  endfunction

  task automatic upd_full();
    for (int n = 0; n < 4; n++)
      CH_FULL[n] = (fifo[n].size() >= PL) && full_mask[n];
  endtask

  task automatic push_pkt(int ch, logic [7:0] first, bit ramp);
    logic [7:0] b;
    fifo[ch].push_back(first);
    for (int i = 1; i < PL; i++) begin
      b = ramp ? 8'(i) : 8'($urandom);
      fifo[ch].push_back(b);
    end
    upd_full();
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge SYS_CLK);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (rd_seen[c]) begin
          chk($sformatf("fifo%0d_nonempty", c), 64'(fifo[c].size() > 0), 64'd1);
          if (fifo[c].size() > 0) CH_DATA[8*c +: 8] = fifo[c].pop_front();
        end
      end
      upd_full();
    end
  endtask

  // Reference arbiter and scoreboard monitor, evaluated mid-cycle.
  always @(negedge SYS_CLK) begin
    logic [3:0] exp_rd;
    logic [3:0] elig;
    logic [1:0] c;
    logic       found;
    logic       exp_serr;
    beat_t      b;
    cyc++;
    rd_seen = CH_RD_REQ;
    if (!RST) begin
      chk("rst_rdreq", 64'(CH_RD_REQ), 64'd0);
      chk("rst_outs", {OUT_DATA, OUT_VALID, OUT_SOP, OUT_EOP, OUT_CH, OUT_SYNC_ERR}, 64'd0);
      chk("rst_pktcnt", PKT_COUNT, 64'd0);
`ifdef TS_SYNC_CHECK_EN
      chk("rst_syncnt", 64'(SYNC_ERR_CNT), 64'd0);
`endif
      exp_q.delete();
      start   = -1000;
      free_at = cyc + 1;
      ptr     = 2'd3;
      mcnt    = '{default: 0};
      msync   = 0;
      prev_rd = '0;
    end else begin
      exp_rd = (cyc >= start && cyc <= start + PL - 1) ? (4'b1 << gch) : 4'b0;
      chk("rdreq", 64'(CH_RD_REQ), 64'(exp_rd));
      chk("valid_window", 64'(OUT_VALID), 64'(cyc >= start + 1 && cyc <= start + PL));
      if (CH_RD_REQ != 0 && prev_rd == 0) begin
        glog_ch.push_back(int'(OUT_CH));
        glog_cyc.push_back(cyc);
      end
      prev_rd = CH_RD_REQ;
      if (OUT_VALID) begin
        if (exp_q.size() == 0) begin
          chk("beat_expected", 64'd0, 64'd1);
        end else begin
          b = exp_q.pop_front();
          chk("data", 64'(OUT_DATA), 64'(b.d));
          chk("sop", 64'(OUT_SOP), 64'(b.sop));
          chk("eop", 64'(OUT_EOP), 64'(b.eop));
          chk("ch", 64'(OUT_CH), 64'(b.ch));
`ifdef TS_SYNC_CHECK_EN
          exp_serr = b.sop && (b.d != 8'h47);
`else
          exp_serr = 1'b0;
`endif
          chk("sync_err", 64'(OUT_SYNC_ERR), 64'(exp_serr));
          if (b.sop) begin
            chk("pktcnt_at_sop", PKT_COUNT, mcnt_packed());
`ifdef TS_SYNC_CHECK_EN
            chk("syncnt_at_sop", 64'(SYNC_ERR_CNT), 64'(msync));
`endif
            if (exp_serr && msync < 65535) msync++;
          end
          if (b.eop) mcnt[b.ch] = (mcnt[b.ch] + 1) % 65536;
        end
      end else begin
        chk("idle_flags", {OUT_DATA, OUT_SOP, OUT_EOP, OUT_SYNC_ERR}, 64'd0);
      end
      elig = CH_FULL & CH_ENABLE;
      if (cyc >= free_at && OUT_READY && elig != 0) begin
        found = 1'b0;
        c = ptr;
        for (int k = 1; k <= 4; k++) begin
          if (!found && elig[(int'(ptr) + k) % 4]) begin
            found = 1'b1;
            c = 2'((int'(ptr) + k) % 4);
          end
        end
        ptr     = c;
        gch     = c;
        start   = cyc + 1;
        free_at = start + PER - 1;
        chk("grant_fifo_full", 64'(fifo[c].size() >= PL), 64'd1);
        for (int i = 0; i < PL && i < fifo[c].size(); i++) begin
          b.d   = fifo[c][i];
          b.sop = (i == 0);
          b.eop = (i == PL - 1);
          b.ch  = c;
          exp_q.push_back(b);
        end
      end
    end
  end

  initial begin
    int  t;
    bit  done;
    CH_ENABLE = 4'hF;
    full_mask = 4'hF;
    OUT_READY = 1'b0;
    CH_DATA   = '0;
    CH_FULL   = '0;
    RST       = 1'b0;
    step(3);
    RST = 1'b1;
    step(2);

    // ch1 alone with ramp payload
    OUT_READY = 1'b1;
    push_pkt(1, 8'h47, 1'b1);
    step(PER + 5);
    chk("t1_pktcnt", PKT_COUNT, 64'h0000_0000_0001_0000);

    // held off by OUT_READY
    OUT_READY = 1'b0;
    push_pkt(2, 8'h47, 1'b0);
    step(20);
    chk("t4_no_rd", 64'(CH_RD_REQ), 64'd0);
    OUT_READY = 1'b1;
    step(PER + 5);

    // eligibility dropped mid-packet
    push_pkt(0, 8'h47, 1'b0);
    step(52);
    full_mask[0] = 1'b0;
    CH_ENABLE[0] = 1'b0;
    upd_full();
    step(PER);
    full_mask = 4'hF;
    CH_ENABLE = 4'hF;
    chk("t3_pktcnt", PKT_COUNT, 64'h0000_0001_0001_0001);

    // reset mid-packet, then all four channels contend
    push_pkt(3, 8'h47, 1'b0);
    step(102);
    RST = 1'b0;
    step(2);
    for (int n = 0; n < 4; n++) fifo[n].delete();
    CH_DATA = '0;
    for (int n = 0; n < 4; n++) begin
      push_pkt(n, 8'h47, 1'b0);
      push_pkt(n, 8'h47, 1'b0);
    end
    glog_ch.delete();
    glog_cyc.delete();
    RST = 1'b1;
    step(8 * PER + 10);
    chk("t2_ngrants", 64'(glog_ch.size()), 64'd8);
    for (int i = 0; i < 8 && i < glog_ch.size(); i++) begin
      chk($sformatf("t2_order%0d", i), 64'(glog_ch[i]), 64'(i % 4));
      if (i > 0)
        chk($sformatf("t2_period%0d", i), 64'(glog_cyc[i] - glog_cyc[i-1]), 64'(PER));
    end

    // bad sync byte, still forwarded
    push_pkt(1, 8'h48, 1'b0);
    step(PER + 5);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      t = int'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0 && fifo[t].size() < 3 * PL)
        push_pkt(t, ($urandom_range(0, 3) == 0) ? 8'h48 : 8'h47, 1'b0);
      if ($urandom_range(0, 39) == 0) CH_ENABLE[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 29) == 0) OUT_READY = 1'($urandom);
      if ($urandom_range(0, 79) == 0) full_mask[$urandom_range(0, 3)] ^= 1'b1;
      upd_full();
      step(1);
    end

    // drain everything left
    CH_ENABLE = 4'hF;
    full_mask = 4'hF;
    OUT_READY = 1'b1;
    upd_full();
    done = 1'b0;
    for (int i = 0; i < 15000 && !done; i++) begin
      step(1);
      done = (exp_q.size() == 0) && (CH_FULL == 0) &&
             (CH_RD_REQ == 0) && !OUT_VALID;
    end
    chk("drain_done", 64'(done), 64'd1);
    step(PER);
    chk("final_pktcnt", PKT_COUNT, mcnt_packed());
    chk("final_exp_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
